// File: rtl/lcd_frame_receiver.sv
// Panel-side receiver for the parallel RGB LCD stream: decodes sync/den/colour into
// addressed pixels plus frame/line events, and checks line and frame geometry.
module lcd_frame_receiver #(
   parameter int unsigned HOR_PIX = 480,
   parameter int unsigned VER_PIX = 272,
   parameter int unsigned CW      = 16
) (
   input  logic          clk_12mhz,
   input  logic          reset_n,
   input  logic          pix_en,
   input  logic          hsync,
   input  logic          vsync,
   input  logic          den,
   input  logic [7:0]    red,
   input  logic [7:0]    green,
   input  logic [7:0]    blue,
   output logic          pix_valid,
   output logic [23:0]   pix_rgb,
   output logic [CW-1:0] pix_x,
   output logic [CW-1:0] pix_y,
   output logic          frame_start,
   output logic          frame_done,
   output logic          line_err,
   output logic          frame_err,
   output logic [CW-1:0] frame_count
);

   localparam logic [CW-1:0] HOR_LIM = CW'(HOR_PIX);
   localparam logic [CW-1:0] VER_LIM = CW'(VER_PIX);

   typedef enum logic [1:0] {
      UNSYNC,
      BLANK,
      ACTIVE
   } state_t;

   state_t        state, state_d;
   logic [CW-1:0] x, x_d;
   logic [CW-1:0] y, y_d;
   logic          bad, bad_d;
   logic          lseen, lseen_d;   // extra-pixel line_err already reported this line
   logic          fseen, fseen_d;   // extra-line frame_err already reported this frame
   logic          drop, drop_d;     // current line is beyond VER_PIX
   logic          valid_d;
   logic [23:0]   rgb_d;
   logic [CW-1:0] px_d, py_d;
   logic          fstart_d, fdone_d, lerr_d, ferr_d;
   logic [CW-1:0] fcount_d;

   always_ff @(posedge clk_12mhz or negedge reset_n) begin
      if (!reset_n) begin
         state       <= UNSYNC;
         x           <= '0;
         y           <= '0;
         bad         <= 1'b0;
         lseen       <= 1'b0;
         fseen       <= 1'b0;
         drop        <= 1'b0;
         pix_valid   <= 1'b0;
         pix_rgb     <= '0;
         pix_x       <= '0;
         pix_y       <= '0;
         frame_start <= 1'b0;
         frame_done  <= 1'b0;
         line_err    <= 1'b0;
         frame_err   <= 1'b0;
         frame_count <= '0;
      end else begin
         state       <= state_d;
         x           <= x_d;
         y           <= y_d;
         bad         <= bad_d;
         lseen       <= lseen_d;
         fseen       <= fseen_d;
         drop        <= drop_d;
         pix_valid   <= valid_d;
         pix_rgb     <= rgb_d;
         pix_x       <= px_d;
         pix_y       <= py_d;
         frame_start <= fstart_d;
         frame_done  <= fdone_d;
         line_err    <= lerr_d;
         frame_err   <= ferr_d;
         frame_count <= fcount_d;
      end
   end

   always_comb begin
      state_d  = state;
      x_d      = x;
      y_d      = y;
      bad_d    = bad;
      lseen_d  = lseen;
      fseen_d  = fseen;
      drop_d   = drop;
      valid_d  = 1'b0;
      rgb_d    = pix_rgb;
      px_d     = pix_x;
      py_d     = pix_y;
      fstart_d = 1'b0;
      fdone_d  = 1'b0;
      lerr_d   = 1'b0;
      ferr_d   = 1'b0;
      fcount_d = frame_count;

      if (pix_en) begin
         // vsync is handled first so that a den in the same sample opens line 0
         if (!vsync) begin
            fstart_d = 1'b1;
            if (state != UNSYNC) begin
               if (y == VER_LIM && !bad) begin
                  fdone_d  = 1'b1;
                  fcount_d = frame_count + 1'b1;
               end else begin
                  ferr_d = 1'b1;
               end
               if (state == ACTIVE) lerr_d = 1'b1;
            end
            state_d = BLANK;
            x_d     = '0;
            y_d     = '0;
            bad_d   = 1'b0;
            lseen_d = 1'b0;
            fseen_d = 1'b0;
            drop_d  = 1'b0;
         end

         case (state_d)
            BLANK: begin
               if (den) begin
                  state_d = ACTIVE;
                  x_d     = CW'(1);
                  lseen_d = 1'b0;
                  if (y_d == VER_LIM) begin
                     drop_d = 1'b1;
                     bad_d  = 1'b1;
                     if (!fseen_d) begin
                        ferr_d  = 1'b1;
                        fseen_d = 1'b1;
                     end
                  end else begin
                     drop_d  = 1'b0;
                     valid_d = 1'b1;
                     rgb_d   = {red, green, blue};
                     px_d    = '0;
                     py_d    = y_d;
                  end
               end
            end
            ACTIVE: begin
               if (!hsync) begin
                  lerr_d = 1'b1;
                  bad_d  = 1'b1;
               end
               if (den) begin
                  if (x < HOR_LIM) begin
                     if (!drop) begin
                        valid_d = 1'b1;
                        rgb_d   = {red, green, blue};
                        px_d    = x;
                        py_d    = y;
                     end
                     x_d = x + 1'b1;
                  end else begin
                     if (!lseen) begin
                        lerr_d  = 1'b1;
                        lseen_d = 1'b1;
                        bad_d   = 1'b1;
                     end
                     if (x != '1) x_d = x + 1'b1;
                  end
               end else begin
                  // an over-long line was already reported on its first extra pixel
                  if (x != HOR_LIM && !lseen) begin
                     lerr_d = 1'b1;
                     bad_d  = 1'b1;
                  end
                  if (y != VER_LIM && y != '1) y_d = y + 1'b1;
                  state_d = BLANK;
                  drop_d  = 1'b0;
                  lseen_d = 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_lcd_frame_receiver.sv
// Directed self-checking bench for lcd_frame_receiver on a reduced 6x3 raster.
module tb_lcd_frame_receiver;

   localparam int HOR = 6;
   localparam int VER = 3;
   localparam int CW  = 16;

   logic          clk_12mhz = 1'b0;
   logic          reset_n   = 1'b0;
   logic          pix_en    = 1'b0;
   logic          hsync     = 1'b1;
   logic          vsync     = 1'b1;
   logic          den       = 1'b0;
   logic [7:0]    red = '0, green = '0, blue = '0;
   logic          pix_valid;
   logic [23:0]   pix_rgb;
   logic [CW-1:0] pix_x, pix_y;
   logic          frame_start, frame_done, line_err, frame_err;
   logic [CW-1:0] frame_count;

   int vectors     = 0;
   int miscompares = 0;
   bit stalls      = 1'b0;

   lcd_frame_receiver #(.HOR_PIX(HOR), .VER_PIX(VER), .CW(CW)) dut (
      .clk_12mhz  (clk_12mhz),
      .reset_n    (reset_n),
      .pix_en     (pix_en),
      .hsync      (hsync),
      .vsync      (vsync),
      .den        (den),
      .red        (red),
      .green      (green),
      .blue       (blue),
      .pix_valid  (pix_valid),
      .pix_rgb    (pix_rgb),
      .pix_x      (pix_x),
      .pix_y      (pix_y),
      .frame_start(frame_start),
      .frame_done (frame_done),
      .line_err   (line_err),
      .frame_err  (frame_err),
      .frame_count(frame_count)
   );

   always #5 clk_12mhz = ~clk_12mhz;

   task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [23:0] colour(input int y, input int i);
      return {8'(y * 37 + i), 8'(i * 11 + 5), 8'(y) ^ 8'hC0};
   endfunction

   // One sample, optionally preceded by pix_en=0 stall cycles; outputs are
   // settled for this sample when the task returns.
   task automatic smp(input logic hs, input logic vs, input logic de, input logic [23:0] c);
      int n;
      n = stalls ? $urandom_range(0, 2) : 0;
      hsync = hs; vsync = vs; den = de; {red, green, blue} = c;
      for (int k = 0; k < n; k++) begin
         pix_en = 1'b0;
         @(posedge clk_12mhz); #1;
         chk("stall_quiet", {frame_start, frame_done, frame_err, line_err, pix_valid}, '0);
      end
      pix_en = 1'b1;
      @(posedge clk_12mhz); #1;
   endtask

   task automatic send_line(input int y, input int n, input int start,
                            input bit live, input bit extra, input bit close);
      bit ev;
      if (start == 0) begin
         smp(1'b0, 1'b1, 1'b0, '0);
         chk("blank_quiet", {frame_start, frame_done, frame_err, line_err, pix_valid}, '0);
         smp(1'b1, 1'b1, 1'b0, '0);
         smp(1'b1, 1'b1, 1'b0, '0);
      end
      for (int i = start; i < n; i++) begin
         smp(1'b1, 1'b1, 1'b1, colour(y, i));
         ev = live && !extra && (i < HOR);
         chk("pix_valid", pix_valid, ev);
         if (ev) begin
            chk("pix_x", pix_x, i);
            chk("pix_y", pix_y, y);
            chk("pix_rgb", pix_rgb, colour(y, i));
         end
         chk("extra_pix_line_err", line_err, live && (i == HOR));
         chk("extra_line_frame_err", frame_err, live && extra && (i == 0));
      end
      if (close) begin
         smp(1'b1, 1'b1, 1'b0, '0);
         chk("line_end_err", line_err, live && (n < HOR));
         chk("line_end_valid", pix_valid, 1'b0);
      end
   endtask

   task automatic vsync_chk(input logic de, input bit done, input bit ferr,
                            input bit lerr, input int count);
      smp(1'b1, 1'b0, de, colour(0, 0));
      chk("frame_start", frame_start, 1'b1);
      chk("frame_done", frame_done, done);
      chk("frame_err", frame_err, ferr);
      chk("vsync_line_err", line_err, lerr);
      chk("frame_count", frame_count, count);
      chk("vsync_pix_valid", pix_valid, de);
      if (de) begin
         chk("vsync_pix_x", pix_x, 0);
         chk("vsync_pix_y", pix_y, 0);
         chk("vsync_pix_rgb", pix_rgb, colour(0, 0));
      end
   endtask

   task automatic good_frame();
      for (int l = 0; l < VER; l++) send_line(l, HOR, 0, 1'b1, 1'b0, 1'b1);
   endtask

   initial begin
      // reset state
      repeat (2) @(posedge clk_12mhz);
      #1;
      chk("reset_outputs", {pix_valid, frame_start, frame_done, line_err, frame_err}, '0);
      chk("reset_count", frame_count, 0);
      chk("reset_xy", {pix_x, pix_y}, '0);
      reset_n = 1'b1;

      // traffic before the first vsync is discarded
      send_line(1, HOR, 0, 1'b0, 1'b0, 1'b1);
      vsync_chk(1'b0, 1'b0, 1'b0, 1'b0, 0);

      // nominal frame, then a nominal frame with random stalls
      good_frame();
      vsync_chk(1'b0, 1'b1, 1'b0, 1'b0, 1);
      stalls = 1'b1;
      good_frame();
      vsync_chk(1'b0, 1'b1, 1'b0, 1'b0, 2);
      stalls = 1'b0;

      // short line 1
      send_line(0, HOR, 0, 1'b1, 1'b0, 1'b1);
      send_line(1, HOR - 1, 0, 1'b1, 1'b0, 1'b1);
      send_line(2, HOR, 0, 1'b1, 1'b0, 1'b1);
      vsync_chk(1'b0, 1'b0, 1'b1, 1'b0, 2);

      // long line 1
      send_line(0, HOR, 0, 1'b1, 1'b0, 1'b1);
      send_line(1, HOR + 2, 0, 1'b1, 1'b0, 1'b1);
      send_line(2, HOR, 0, 1'b1, 1'b0, 1'b1);
      vsync_chk(1'b0, 1'b0, 1'b1, 1'b0, 2);

      // one line too many, then one line too few
      good_frame();
      send_line(VER, HOR, 0, 1'b1, 1'b1, 1'b1);
      vsync_chk(1'b0, 1'b0, 1'b1, 1'b0, 2);
      send_line(0, HOR, 0, 1'b1, 1'b0, 1'b1);
      send_line(1, HOR, 0, 1'b1, 1'b0, 1'b1);
      vsync_chk(1'b0, 1'b0, 1'b1, 1'b0, 2);

      // vsync truncating an active line, with den opening line 0 in that sample
      send_line(0, HOR, 0, 1'b1, 1'b0, 1'b1);
      send_line(1, HOR, 0, 1'b1, 1'b0, 1'b1);
      send_line(2, 3, 0, 1'b1, 1'b0, 1'b0);
      vsync_chk(1'b1, 1'b0, 1'b1, 1'b1, 2);
      send_line(0, HOR, 1, 1'b1, 1'b0, 1'b1);
      send_line(1, HOR, 0, 1'b1, 1'b0, 1'b1);
      send_line(2, HOR, 0, 1'b1, 1'b0, 1'b1);
      vsync_chk(1'b0, 1'b1, 1'b0, 1'b0, 3);

      // asynchronous reset mid-line, then re-sync
      send_line(0, 3, 0, 1'b1, 1'b0, 1'b0);
      reset_n = 1'b0;
      #1;
      chk("midline_reset_outputs", {pix_valid, frame_start, frame_done, line_err, frame_err}, '0);
      chk("midline_reset_count", frame_count, 0);
      smp(1'b1, 1'b0, 1'b1, colour(0, 3));
      chk("held_reset_outputs", {pix_valid, frame_start, frame_done, line_err, frame_err}, '0);
      reset_n = 1'b1;
      send_line(1, HOR, 0, 1'b0, 1'b0, 1'b1);
      vsync_chk(1'b0, 1'b0, 1'b0, 1'b0, 0);
      good_frame();
      vsync_chk(1'b0, 1'b1, 1'b0, 1'b0, 1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/lcd_frame_receiver.md
# lcd_frame_receiver

Panel-side receiver for the parallel RGB LCD interface that the GPU palette stage drives: sync, data-enable and 24-bit colour. It decodes that stream back into addressed pixels (x, y, rgb) and frame and line events, and checks line and frame geometry. It is used for GPU loopback self-test and as the capture front end of the frame-checker testbench. It sits directly on the LCD pins, in the 12 MHz pixel-clock domain.

## Interface
- HOR_PIX, 480, active pixels per line
- VER_PIX, 272, active lines per frame
- CW, 16, width of the coordinate and frame counters

- clk_12mhz  input  1  pixel-domain clock; all logic on its rising edge
- reset_n  input  1  asynchronous, active-low reset
- pix_en  input  1  a panel dclk edge occurred this cycle (the dclk gate); inputs are sampled only when pix_en=1
- hsync  input  1  horizontal sync, active low, one sample wide
- vsync  input  1  vertical sync, active low, one sample wide
- den  input  1  data enable, active high
- red, green, blue  input  8 each  pixel colour
- pix_valid  output  1  pix_rgb/pix_x/pix_y hold a decoded active pixel
- pix_rgb  output  24  {red, green, blue} of that pixel
- pix_x, pix_y  output  CW each  pixel coordinates, 0-based
- frame_start  output  1  one-cycle pulse on an accepted vsync
- frame_done  output  1  one-cycle pulse: the previous frame had exactly VER_PIX good lines
- line_err  output  1  one-cycle pulse on a line-length violation
- frame_err  output  1  one-cycle pulse on a frame-height violation
- frame_count  output  CW  count of frame_done pulses, wraps at 2^CW

## Operation
- A "sample" is a rising edge of clk_12mhz with pix_en=1. When pix_en=0, all state and counters hold, and every pulse output and pix_valid are 0.
- States:
  - UNSYNC: entered on reset. Discards everything until a sample has vsync=0, then goes to BLANK.
  - BLANK: waits between lines. A sample with den=1 captures the pixel at x=0 and goes to ACTIVE.
  - ACTIVE: each den=1 sample emits the next pixel and increments x. A den=0 sample ends the line: check x, then y++ and go to BLANK.
- Line check: on line end, if x != HOR_PIX, pulse line_err and mark the frame bad.
- Extra pixels: any den=1 sample after HOR_PIX pixels pulses line_err once per line. Those pixels are dropped (pix_valid=0).
- Extra lines: a line starting when y == VER_PIX pulses frame_err once per frame. Its pixels are dropped and y saturates.
- Frame boundary: a vsync=0 sample seen in BLANK or ACTIVE:
  - Pulse frame_start.
  - If the previous frame was not the first since UNSYNC, evaluate it. If y == VER_PIX and the frame is not marked bad, pulse frame_done and increment frame_count. Otherwise pulse frame_err.
  - Reset x, y and the bad flag.
- vsync while ACTIVE: line_err pulses as well (truncated line), in the same cycle as frame_err. The state goes to BLANK.
- hsync carries no decoding role; den bounds each line. An hsync=0 sample while ACTIVE pulses line_err.
- Simultaneous vsync=0 and den=1: vsync is processed first, then den opens line 0 in the same sample.
- Arithmetic: x and y are CW-bit and saturate at 2^CW-1; they never wrap. frame_count wraps modulo 2^CW.

## Timing
- Reset values: all outputs 0, and the state is UNSYNC. Reset is honoured immediately at any point, including mid-line. After release the block re-syncs on the next vsync, and that first boundary produces no frame_done or frame_err.
- Latency: outputs are registered, so the sample at edge N appears on outputs after edge N, one cycle.
- pix_valid is high for exactly one cycle per accepted pixel. No back-pressure: the consumer must accept every pixel.
- frame_start, frame_done and frame_err for one boundary assert in the same cycle. frame_count updates in that same cycle.
- With the GPU writer's timing (THFP=2, THBP=43, TVFP=1, TVBP=12), the first pixel (0,0) appears 45 samples after the hsync that follows the 13th line after vsync.

## Test plan
- Two nominal 480x272 frames from a timing model with pix_en=1 continuously. Required: 130560 pix_valid pulses per frame, x 0..479 and y 0..271 in raster order, rgb matching. At the second vsync: frame_start, frame_done, frame_count=1, and no errors.
- Same stimulus with pix_en low on random cycles (stalls). Required: an identical pixel sequence and identical events; nothing emitted on pix_en=0 cycles.
- Line 100 carries 479 pixels. Required: one line_err at that line's end, the remaining lines still decode, and the next vsync gives frame_err with no frame_done and frame_count unchanged.
- Line 5 carries 482 pixels. Required: line_err on the 481st pixel, 480 pixels emitted for line 5, then frame_err at the next vsync.
- Frame of 273 lines, then a frame of 271 lines. Required: frame_err on line 273 (its pixels dropped) and frame_err at both following vsyncs.
- Assert reset_n=0 mid-line 50, then release. Required: outputs 0 during reset, nothing decoded until vsync, and the next full frame yields frame_done with frame_count=1.
